// File: rtl/qspi_ddr_shifter_if.sv
// Controller/pin bundle for qspi_ddr_shifter: byte request handshake, returned
// byte, and the CS#/SCK/DQ DDR pin pairs.
interface qspi_ddr_shifter_if;
  logic       i_stb;
  logic       i_quad;
  logic       i_dir;
  logic       i_last;
  logic [7:0] i_byte;
  logic       o_busy;
  logic       o_valid;
  logic [7:0] o_byte;
  logic       o_cs_n;
  logic [1:0] o_sck;
  logic [3:0] o_dq_oe;
  logic [7:0] o_dq;
  logic [7:0] i_dq;

  modport slave (
    input  i_stb, i_quad, i_dir, i_last, i_byte, i_dq,
    output o_busy, o_valid, o_byte, o_cs_n, o_sck, o_dq_oe, o_dq
  );

  modport master (
    output i_stb, i_quad, i_dir, i_last, i_byte, i_dq,
    input  o_busy, o_valid, o_byte, o_cs_n, o_sck, o_dq_oe, o_dq
  );
endinterface

// File: rtl/qspi_ddr_shifter.sv
// Byte-level QSPI shift engine feeding per-pin DDR I/O cells; SPI always,
// quad read/write only when QSPI_QUAD_EN is defined.
module qspi_ddr_shifter #(
  parameter int RDDELAY = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  qspi_ddr_shifter_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_DRAIN, S_HOLD, S_RELEASE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   byte_q;
  logic         last_q;
  logic [6:0]   rx_q;
  logic [7:0]   rx_d;
  logic [2:0]   rx_cnt_q;
  logic         valid_q;
  logic [7:0]   obyte_q;
  logic [RDDELAY-1:0] tag_q;

  logic         accept;
  logic         tag_out;
  logic         rx_final;
  logic [2:0]   last_idx;
  logic         cs_n;
  logic [1:0]   sck;
  logic [3:0]   dq_oe;
  logic [7:0]   dq;
  logic         busy;
  logic [7:0]   spi_dq;
  logic         unused_sig;

`ifdef QSPI_QUAD_EN
  logic         quad_q;
  logic         dir_q;
  logic [3:0]   nib;

  assign last_idx   = quad_q ? 3'd1 : 3'd7;
  assign nib        = cnt_q[0] ? byte_q[3:0] : byte_q[7:4];
  assign rx_d       = quad_q ? {rx_q[3:0], bus.i_dq[7], bus.i_dq[5], bus.i_dq[3], bus.i_dq[1]}
                             : {rx_q, bus.i_dq[3]};
  assign unused_sig = ^{bus.i_dq[6], bus.i_dq[4], bus.i_dq[2], bus.i_dq[0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      quad_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (accept) begin
      quad_q <= bus.i_quad;
      dir_q  <= bus.i_dir;
    end
  end
`else
  assign last_idx   = 3'd7;
  assign rx_d       = {rx_q, bus.i_dq[3]};
  assign unused_sig = ^{bus.i_dq[7:4], bus.i_dq[2:0], bus.i_quad, bus.i_dir};
`endif

  assign accept   = bus.i_stb && (state_q == S_IDLE || state_q == S_HOLD);
  assign tag_out  = tag_q[RDDELAY-1];
  assign rx_final = tag_out && (rx_cnt_q == last_idx);
  // WP#/HOLD# stay high; DQ0 carries the current MSB-first bit on both edges.
  assign spi_dq   = {4'hF, 2'b00, {2{byte_q[3'd7 - cnt_q]}}};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        byte_q <= bus.i_byte;
        last_q <= bus.i_last;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n    = 1'b0;
    sck     = 2'b00;
    dq_oe   = 4'b1100;
    dq      = 8'hF0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        cs_n = 1'b1;
        busy = 1'b0;
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = 3'd0;
        end
      end
      S_SETUP: state_d = S_SHIFT;
      S_SHIFT: begin
        sck   = 2'b01;
        dq_oe = 4'b1101;
        dq    = spi_dq;
`ifdef QSPI_QUAD_EN
        if (quad_q && dir_q) begin
          dq_oe = 4'b1111;
          dq    = {{2{nib[3]}}, {2{nib[2]}}, {2{nib[1]}}, {2{nib[0]}}};
        end else if (quad_q) begin
          dq_oe = 4'b0000;
          dq    = 8'h00;
        end
`endif
        if (cnt_q == last_idx) state_d = S_DRAIN;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      S_DRAIN: begin
        // Non-final bytes leave with the capture so the next request can
        // overlap o_valid; a final byte lingers one cycle before CS# rises.
        if (rx_final && !last_q)     state_d = S_HOLD;
        else if (valid_q && last_q)  state_d = S_RELEASE;
      end
      S_HOLD: begin
        busy = 1'b0;
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = 3'd0;
        end
      end
      S_RELEASE: begin
        cs_n    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid-tag delay line: tag_q[k] marks a SHIFT cycle k+1 clocks ago.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tag_q[0] <= 1'b0;
    else         tag_q[0] <= (state_q == S_SHIFT);
  end

  generate
    for (genvar gi = 1; gi < RDDELAY; gi++) begin : g_tag
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) tag_q[gi] <= 1'b0;
        else         tag_q[gi] <= tag_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_q     <= 7'd0;
      rx_cnt_q <= 3'd0;
      valid_q  <= 1'b0;
      obyte_q  <= 8'h00;
    end else begin
      valid_q <= rx_final;
      if (tag_out) begin
        rx_q     <= rx_d[6:0];
        rx_cnt_q <= rx_final ? 3'd0 : rx_cnt_q + 3'd1;
      end
      if (rx_final) obyte_q <= rx_d;
    end
  end

  assign bus.o_busy  = busy;
  assign bus.o_valid = valid_q;
  assign bus.o_byte  = obyte_q;
  assign bus.o_cs_n  = cs_n;
  assign bus.o_sck   = sck;
  assign bus.o_dq_oe = dq_oe;
  assign bus.o_dq    = dq;

endmodule

// File: tb/tb_qspi_ddr_shifter.sv
// Directed bench for qspi_ddr_shifter with a 3-cycle pin loopback model;
// quad cases run only when QSPI_QUAD_EN is defined.
module tb_qspi_ddr_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  qspi_ddr_shifter_if ifc ();

  qspi_ddr_shifter #(.RDDELAY(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  // Pin model: SPI loops DQ0 back onto DQ1; quad-read mode returns 9 then 6.
  logic [7:0] pipe0 = 8'h00, pipe1 = 8'h00, pipe2 = 8'h00;
  logic [7:0] src;
  bit         quad_rd = 1'b0;
  bit         q_idx   = 1'b0;

  assign ifc.i_dq = pipe2;

  always @(posedge clk) begin
    src = {4'b0000, ifc.o_dq[1:0], 2'b00};
    if (quad_rd && ifc.o_sck == 2'b01) begin
      src   = q_idx ? 8'h3C : 8'hC3;
      q_idx <= ~q_idx;
    end
    if (!quad_rd) q_idx <= 1'b0;
    pipe0 <= src;
    pipe1 <= pipe0;
    pipe2 <= pipe1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit quad, input bit dir, input bit last, input logic [7:0] b);
    ifc.i_stb  = 1'b1;
    ifc.i_quad = quad;
    ifc.i_dir  = dir;
    ifc.i_last = last;
    ifc.i_byte = b;
  endtask

  logic [7:0] a5_bits = 8'b10100101;
  int         cs_high;
  int         valids;

  initial begin
    ifc.i_stb  = 1'b0;
    ifc.i_quad = 1'b0;
    ifc.i_dir  = 1'b0;
    ifc.i_last = 1'b0;
    ifc.i_byte = 8'h00;

    repeat (3) tick();
    check("rst_cs_n",  ifc.o_cs_n,  1);
    check("rst_sck",   ifc.o_sck,   2'b00);
    check("rst_oe",    ifc.o_dq_oe, 4'b1100);
    check("rst_dq",    ifc.o_dq,    8'hF0);
    check("rst_busy",  ifc.o_busy,  0);
    check("rst_valid", ifc.o_valid, 0);
    check("rst_byte",  ifc.o_byte,  8'h00);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_cs_n", ifc.o_cs_n, 1);
    check("idle_oe",   ifc.o_dq_oe, 4'b1100);

    // SPI A5, last byte; a stray request mid-shift must be ignored
    req(0, 0, 1, 8'hA5);
    tick();
    ifc.i_stb = 1'b0;
    check("spi_setup_cs", ifc.o_cs_n, 0);
    check("spi_setup_sck", ifc.o_sck, 2'b00);
    check("spi_setup_busy", ifc.o_busy, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("spi_sck", ifc.o_sck, 2'b01);
      check("spi_oe", ifc.o_dq_oe, 4'b1101);
      check("spi_dq0", ifc.o_dq[1:0], {2{a5_bits[7-k]}});
      check("spi_dq_hi", ifc.o_dq[7:2], 6'b111100);
      if (k == 3) req(0, 0, 0, 8'hFF);
      if (k == 4) ifc.i_stb = 1'b0;
    end
    valids = 0;
    for (int c = 10; c <= 12; c++) begin
      tick();
      if (ifc.o_valid) valids++;
    end
    check("spi_early_valid", valids, 0);
    check("spi_drain_oe", ifc.o_dq_oe, 4'b1100);
    tick();
    check("spi_valid13", ifc.o_valid, 1);
    check("spi_byte", ifc.o_byte, 8'hA5);
    check("spi_cs13", ifc.o_cs_n, 0);
    $display("txn spi byte=a5 last=1 rx=%0h", ifc.o_byte);
    tick();
    check("spi_rel_cs", ifc.o_cs_n, 1);
    check("spi_rel_busy", ifc.o_busy, 1);
    check("spi_rel_valid", ifc.o_valid, 0);
    tick();
    check("spi_idle_busy", ifc.o_busy, 0);
    check("spi_idle_dq", ifc.o_dq, 8'hF0);
    tick();
    check("spi_stray_ignored", ifc.o_busy, 0);

    // Two SPI bytes back to back, CS# held low between them
    req(0, 0, 0, 8'h3C);
    tick();
    ifc.i_stb = 1'b0;
    cs_high = 0;
    for (int c = 1; c <= 12; c++) begin
      if (ifc.o_cs_n) cs_high++;
      tick();
    end
    check("b2b_valid1", ifc.o_valid, 1);
    check("b2b_byte1", ifc.o_byte, 8'h3C);
    check("b2b_busy1", ifc.o_busy, 0);
    $display("txn spi byte=3c last=0 rx=%0h", ifc.o_byte);
    req(0, 0, 1, 8'hC3);
    tick();
    ifc.i_stb = 1'b0;
    check("b2b_shift_now", ifc.o_sck, 2'b01);
    for (int c = 14; c <= 24; c++) begin
      if (ifc.o_cs_n) cs_high++;
      tick();
    end
    check("b2b_cs_low", cs_high, 0);
    check("b2b_valid2", ifc.o_valid, 1);
    check("b2b_byte2", ifc.o_byte, 8'hC3);
    $display("txn spi byte=c3 last=1 rx=%0h", ifc.o_byte);
    tick();
    check("b2b_rel_cs", ifc.o_cs_n, 1);
    tick();
    check("b2b_idle_busy", ifc.o_busy, 0);

`ifdef QSPI_QUAD_EN
    // Quad write 3C
    req(1, 1, 1, 8'h3C);
    tick();
    ifc.i_stb = 1'b0;
    tick();
    check("qw_oe2", ifc.o_dq_oe, 4'b1111);
    check("qw_dq2", ifc.o_dq, 8'h0F);
    tick();
    check("qw_oe3", ifc.o_dq_oe, 4'b1111);
    check("qw_dq3", ifc.o_dq, 8'hF0);
    repeat (3) tick();
    check("qw_novalid6", ifc.o_valid, 0);
    tick();
    check("qw_valid7", ifc.o_valid, 1);
    $display("txn quad write byte=3c");
    repeat (3) tick();
    check("qw_idle", ifc.o_busy, 0);

    // Quad read, pins return 9 then 6
    quad_rd = 1'b1;
    req(1, 0, 1, 8'h00);
    tick();
    ifc.i_stb = 1'b0;
    tick();
    check("qr_oe2", ifc.o_dq_oe, 4'b0000);
    tick();
    check("qr_oe3", ifc.o_dq_oe, 4'b0000);
    repeat (4) tick();
    check("qr_valid7", ifc.o_valid, 1);
    check("qr_byte", ifc.o_byte, 8'h96);
    $display("txn quad read rx=%0h", ifc.o_byte);
    quad_rd = 1'b0;
    repeat (3) tick();
    check("qr_idle", ifc.o_busy, 0);
`endif

    // Reset in the middle of a shift
    req(0, 0, 1, 8'h5A);
    tick();
    ifc.i_stb = 1'b0;
    repeat (4) tick();
    check("rst_mid_shift", ifc.o_sck, 2'b01);
    #2 rst = 1'b1;
    ifc.i_stb = 1'b1;
    #1;
    check("rst_mid_cs", ifc.o_cs_n, 1);
    check("rst_mid_sck", ifc.o_sck, 2'b00);
    check("rst_mid_oe", ifc.o_dq_oe, 4'b1100);
    check("rst_mid_busy", ifc.o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ifc.i_stb = 1'b0;
    valids = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifc.o_valid) valids++;
    end
    check("rst_mid_novalid", valids, 0);
    check("rst_mid_byte", ifc.o_byte, 8'h00);
    check("rst_mid_idle", ifc.o_cs_n, 1);
    $display("txn spi byte=5a aborted by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
